// File: rtl/s4ga_pkg.sv
// s4ga_pkg: shared geometry helpers and FSM state for the S4GA
// configuration streamer.
package s4ga_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    RUN  = 2'd2
  } state_e;

  function automatic int cdiv(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int n_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int idx_segs(input int n, input int si_w);
    return cdiv(n_w(n), si_w);
  endfunction

  function automatic int mask_segs(input int k, input int si_w);
    return cdiv(1 << k, si_w);
  endfunction

  function automatic int frame_segs(input int n, input int k,
                                    input int si_w);
    return k * idx_segs(n, si_w) + mask_segs(k, si_w);
  endfunction

endpackage

// File: rtl/s4ga_seg_ram.sv
// s4ga_seg_ram: 1R1W segment memory, registered read, read-before-write.
// Out-of-range write addresses are dropped.
module s4ga_seg_ram #(
  parameter int DEPTH = 1422,
  parameter int W     = 4,
  parameter int A_W   = 11
) (
  input  logic           clk,
  input  logic           we_i,
  input  logic [A_W-1:0] waddr_i,
  input  logic [W-1:0]   wdata_i,
  input  logic [A_W-1:0] raddr_i,
  output logic [W-1:0]   rdata_o
);

  localparam logic [A_W:0] LIM = (A_W+1)'(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i && ({1'b0, waddr_i} < LIM))
      mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/s4ga_cfg_streamer.sv
// s4ga_cfg_streamer: holds the fabric's LUT frames and streams them to
// the target after a reset window, looping pass after pass.
module s4ga_cfg_streamer
  import s4ga_pkg::*;
#(
  parameter  int N          = 79,
  parameter  int K          = 5,
  parameter  int O          = 8,
  parameter  int SI_W       = 4,
  localparam int N_W        = n_w(N),
  localparam int IDX_SEGS   = cdiv(N_W, SI_W),
  localparam int MASK_SEGS  = mask_segs(K, SI_W),
  localparam int FRAME_SEGS = K * IDX_SEGS + MASK_SEGS,
  localparam int DEPTH      = N * FRAME_SEGS,
  localparam int A_W        = $clog2(DEPTH),
  localparam int RST_CYC    = ((N > O) ? N : O) + 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic            wr_en,
  input  logic [A_W-1:0]  wr_addr,
  input  logic [SI_W-1:0] wr_data,
  output logic [SI_W-1:0] si,
  output logic            tgt_rst,
  output logic            busy,
  output logic            pass_done,
  output logic [15:0]     pass_cnt
);

  localparam int C_W = $clog2(RST_CYC + 1);
  localparam logic [A_W-1:0] LAST  = A_W'(DEPTH - 1);
  localparam logic [C_W-1:0] CLAST = C_W'(RST_CYC - 1);

  state_e          state_q;
  logic [A_W-1:0]  addr_q;
  logic [A_W-1:0]  addr_d;
  logic [A_W-1:0]  rd_addr;
  logic [C_W-1:0]  cnt_q;
  logic            tgt_rst_q;
  logic            busy_q;
  logic            done_q;
  logic [15:0]     pcnt_q;
  logic [SI_W-1:0] rdata;

  // Outside RUN the RAM is aimed at address 0, so the last RST
  // cycle prefetches the first segment.
  always_comb begin
    addr_d  = (addr_q == LAST) ? '0 : addr_q + A_W'(1);
    rd_addr = (state_q == RUN) ? addr_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      tgt_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pcnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q <= RST;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RST: begin
          if (stop) begin
            state_q <= IDLE;
            addr_q  <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CLAST) begin
            state_q   <= RUN;
            addr_q    <= '0;
            tgt_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + C_W'(1);
          end
        end
        RUN: begin
          if (stop) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            tgt_rst_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            addr_q <= addr_d;
            if (addr_q == LAST) begin
              done_q <= 1'b1;
              pcnt_q <= pcnt_q + 16'd1;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          addr_q    <= '0;
          tgt_rst_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  s4ga_seg_ram #(
    .DEPTH (DEPTH),
    .W     (SI_W),
    .A_W   (A_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rdata)
  );

  assign si        = (state_q == RUN) ? rdata : '0;
  assign tgt_rst   = tgt_rst_q;
  assign busy      = busy_q;
  assign pass_done = done_q;
  assign pass_cnt  = pcnt_q;

endmodule

// File: tb/tb_s4ga_cfg_streamer.sv
// tb_s4ga_cfg_streamer: handshake vector table, directed streaming
// scenarios and randomized writes against a memory/stream model.
module tb_s4ga_cfg_streamer;

  localparam int N          = 79;
  localparam int K          = 5;
  localparam int O          = 8;
  localparam int SI_W       = 4;
  localparam int N_W        = $clog2(N);
  localparam int IDX_SEGS   = (N_W + SI_W - 1) / SI_W;
  localparam int MASK_SEGS  = ((1 << K) + SI_W - 1) / SI_W;
  localparam int FRAME_SEGS = K * IDX_SEGS + MASK_SEGS;
  localparam int DEPTH      = N * FRAME_SEGS;
  localparam int A_W        = $clog2(DEPTH);
  localparam int RST_CYC    = ((N > O) ? N : O) + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            stop;
  logic            wr_en;
  logic [A_W-1:0]  wr_addr;
  logic [SI_W-1:0] wr_data;
  logic [SI_W-1:0] si;
  logic            tgt_rst;
  logic            busy;
  logic            pass_done;
  logic [15:0]     pass_cnt;

  s4ga_cfg_streamer #(
    .N    (N),
    .K    (K),
    .O    (O),
    .SI_W (SI_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .si        (si),
    .tgt_rst   (tgt_rst),
    .busy      (busy),
    .pass_done (pass_done),
    .pass_cnt  (pass_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic start;
    logic stop;
    logic busy;
    logic tgt;
  } vec_t;

  int              n_tests = 0;
  int              n_fail  = 0;
  logic [SI_W-1:0] model_mem [DEPTH];
  logic [SI_W-1:0] hist [$];
  logic [SI_W-1:0] exp_si;
  logic [15:0]     m_pcnt;
  int              run_c;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic write_mem(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = A_W'(a);
    wr_data = SI_W'(d);
    tick();
    wr_en = 1'b0;
    if (a < DEPTH) model_mem[a] = SI_W'(d);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".busy"}, busy, 0);
    chk({nm, ".tgt_rst"}, tgt_rst, 1);
    chk({nm, ".si"}, si, 0);
    chk({nm, ".pass_done"}, pass_done, 0);
    chk({nm, ".pass_cnt"}, pass_cnt, m_pcnt);
  endtask

  // Pulse start from IDLE and check the whole reset window.
  task automatic start_seq();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < RST_CYC; i++) begin
      chk($sformatf("rst_win.tgt_rst@%0d", i), tgt_rst, 1);
      chk($sformatf("rst_win.busy@%0d", i), busy, 1);
      chk($sformatf("rst_win.si@%0d", i), si, 0);
      chk($sformatf("rst_win.pass_done@%0d", i), pass_done, 0);
      tick();
    end
    exp_si = model_mem[0];
    run_c  = 0;
    hist.delete();
  endtask

  task automatic stop_seq(input string nm);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_idle(nm);
  endtask

  // Each displayed segment is the memory value at the moment it was read,
  // i.e. one cycle earlier and before that cycle's write lands.
  task automatic run_cycles(input int n, input int wr_pct, input int fw_c,
                            input int fw_a, input int fw_d);
    for (int i = 0; i < n; i++) begin
      bit pd;
      int wa;
      int wd;
      pd = (run_c > 0) && (run_c % DEPTH == 0);
      if (pd) m_pcnt++;
      chk($sformatf("si@%0d", run_c), si, exp_si);
      chk($sformatf("pass_done@%0d", run_c), pass_done, pd);
      chk($sformatf("pass_cnt@%0d", run_c), pass_cnt, m_pcnt);
      chk($sformatf("run.tgt_rst@%0d", run_c), tgt_rst, 0);
      hist.push_back(si);
      wa = 0;
      wd = 0;
      if (run_c == fw_c) begin
        wa    = fw_a;
        wd    = fw_d;
        wr_en = 1'b1;
      end else if (int'($urandom_range(99)) < wr_pct) begin
        wa    = int'($urandom_range(DEPTH + 40));
        wd    = int'($urandom_range(15));
        wr_en = 1'b1;
      end
      wr_addr = A_W'(wa);
      wr_data = SI_W'(wd);
      exp_si  = model_mem[(run_c + 1) % DEPTH];
      if (wr_en && wa < DEPTH) model_mem[wa] = SI_W'(wd);
      tick();
      wr_en = 1'b0;
      run_c++;
    end
  endtask

  vec_t            vt [9];
  logic [SI_W-1:0] lut3_exp [18];
  logic [31:0]     mask;

  initial begin
    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b1};
    vt[1] = '{1'b1, 1'b1, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b0, 1'b1, 1'b1};
    vt[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b1};
    vt[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
    vt[7] = '{1'b1, 1'b0, 1'b1, 1'b1};
    vt[8] = '{1'b0, 1'b1, 1'b0, 1'b1};
    lut3_exp = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h3, 4'h0,
                 4'h4, 4'hC, 4'hA, 4'hF, 4'hE, 4'hB, 4'hA, 4'hB, 4'hE};

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    m_pcnt = '0; run_c = 0; exp_si = '0;
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();

    // Handshake table: start/stop priority and ignored starts.
    for (int i = 0; i < 9; i++) begin
      start = vt[i].start;
      stop  = vt[i].stop;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      chk($sformatf("vec%0d.busy", i), busy, vt[i].busy);
      chk($sformatf("vec%0d.tgt_rst", i), tgt_rst, vt[i].tgt);
      chk($sformatf("vec%0d.si", i), si, 0);
    end

    // Ramp pattern, two full passes plus wrap.
    for (int a = 0; a < DEPTH; a++) write_mem(a, a % 16);
    start_seq();
    run_cycles(2 * DEPTH + 3, 0, -1, 0, 0);
    for (int i = 0; i < 20; i++)
      chk($sformatf("ramp[%0d]", i), hist[i], i % 16);
    chk("wrap.last", hist[DEPTH-1], (DEPTH - 1) % 16);
    chk("wrap.first", hist[DEPTH], 0);
    chk("two_passes", pass_cnt, 2);
    stop_seq("stop_after_2");

    // LUT 3 frame from index and mask fields, MS segment first.
    mask = 32'hCAFEBABE;
    for (int k = 0; k < K; k++)
      for (int s = 0; s < IDX_SEGS; s++)
        write_mem(3 * FRAME_SEGS + k * IDX_SEGS + s,
                  (k >> (SI_W * (IDX_SEGS - 1 - s))) & 15);
    for (int s = 0; s < MASK_SEGS; s++)
      write_mem(3 * FRAME_SEGS + K * IDX_SEGS + s,
                int'((mask >> (SI_W * (MASK_SEGS - 1 - s))) & 32'hF));
    start_seq();
    run_cycles(80, 0, -1, 0, 0);
    for (int j = 0; j < 18; j++)
      chk($sformatf("lut3[%0d]", 54 + j), hist[54+j], lut3_exp[j]);
    stop_seq("stop_after_lut3");

    // Stop at RUN cycle 500, one IDLE cycle, then a full restart.
    start_seq();
    run_cycles(500, 0, -1, 0, 0);
    stop_seq("stop_at_500");
    start_seq();
    run_cycles(20, 0, -1, 0, 0);
    chk("restart.first", hist[0], model_mem[0]);
    stop_seq("stop_after_restart");

    // Same-address read/write and an out-of-range write.
    write_mem(10, 5);
    write_mem(DEPTH, 15);
    start_seq();
    run_cycles(DEPTH + 15, 0, 9, 10, 9);
    chk("rbw.old", hist[10], 5);
    chk("rbw.new", hist[DEPTH+10], 9);
    stop_seq("stop_after_rbw");

    // Random writes while streaming.
    start_seq();
    run_cycles(2 * DEPTH + 20, 35, -1, 0, 0);

    // Asynchronous reset mid-RUN, then memory must survive.
    #2 rst = 1'b1;
    #1;
    m_pcnt = '0;
    chk_idle("async_rst");
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle($sformatf("post_rst%0d", i));
    end
    start_seq();
    run_cycles(DEPTH + 5, 0, -1, 0, 0);
    chk("post_rst.passes", pass_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
